regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
Write-back controller for the 32x`XLEN register file. It shares the register file's single write port (rd_addr/rd_data/rd_en) among NUM_SRC write-back requesters (ALU, LSU, CSR/MUL) using round-robin arbitration. It also keeps a per-register pending-write scoreboard that the decode stage queries for RAW/WAW hazards.

Parameters:
NUM_SRC, 3, number of write-back requesters (2..4)
SRC_IDX_W, 2, width of the grant index; must satisfy 2**SRC_IDX_W >= NUM_SRC

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_SRC  per-source write-back request
req_addr  input  5*NUM_SRC  per-source destination register; source i at [5i+4:5i]
req_data  input  `XLEN*NUM_SRC  per-source write data; source i at slice i
req_ready  output  NUM_SRC  one-hot grant, combinational
wb_en  output  1  to regfile rd_en, registered
wb_addr  output  5  to regfile rd_addr, registered
wb_data  output  `XLEN  to regfile rd_data, registered
issue_en  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  5  destination of the issuing instruction
rs1_q  input  5  hazard query address 1
rs2_q  input  5  hazard query address 2
rs1_busy  output  1  rs1_q has a pending write
rs2_busy  output  1  rs2_q has a pending write
issue_rd_busy  output  1  issue_rd has a pending write (WAW)
flush  input  1  clear the scoreboard (pipeline flush)

Behaviour:
- Reset: wb_en=0, wb_addr=0, wb_data=0, scoreboard all 0, rr pointer=0. req_ready is 0 while no request is valid.
- Arbitration is combinational. Priority starts at the rr pointer and rotates upward mod NUM_SRC. The first valid source is granted, and exactly one req_ready is high when any req_valid is high. A handshake is req_valid&req_ready.
- After a handshake by source g, the rr pointer becomes (g+1) mod NUM_SRC. With no handshake the pointer holds.
- Latency: a handshake in cycle T gives wb_en=1, wb_addr, wb_data in cycle T+1. The regfile writes at the end of T+1, and the data is readable in T+2.
- With no handshake in cycle T, wb_en=0 in T+1. wb_addr and wb_data hold their previous values.
- A request to x0 is still granted and consumed, but wb_en stays 0 and the scoreboard is untouched.
- Scoreboard sb[31:1], 1 bit per register; sb[0] is constant 0.
- Set: issue_en and issue_rd!=0 set sb[issue_rd] at the clock edge.
- Clear: wb_en and wb_addr!=0 clear sb[wb_addr] at the same edge where the regfile writes.
- Set and clear of the same register in one cycle: set wins, so the bit stays 1 (a new writer is pending).
- flush=1 clears all sb bits at the edge and overrides set and clear that cycle. flush does not cancel a registered wb_en already in flight; that write still reaches the regfile.
- rs1_busy=sb[rs1_q], rs2_busy=sb[rs2_q], issue_rd_busy=sb[issue_rd]. All are combinational from the registered scoreboard, with no bypass of a same-cycle clear. Query of x0 returns 0.
- Decode must not assert issue_en while issue_rd_busy=1. The block does not check this; behaviour is then only the set rule above.
- Reset mid-operation: all state returns immediately to reset values, and a pending wb is dropped.
- Requester data must be held stable while req_valid=1 and req_ready=0. Requesters may not withdraw an ungranted request.

Test Plan:
- Reset, then src1 req addr=5 data=0xDEADBEEF alone -> req_ready=3'b010 in T; wb_en=1 wb_addr=5 wb_data=0xDEADBEEF in T+1; wb_en=0 in T+2.
- All 3 sources valid continuously (addr 1,2,3) -> grants 0,1,2,0,1,2 on consecutive cycles; wb_addr 1,2,3,1,2,3 one cycle later.
- issue_en issue_rd=7, then rs1_q=7 -> rs1_busy=1. LSU writes addr 7 -> rs1_busy=0 in the cycle after wb_en=1 with wb_addr=7.
- Same cycle: wb_en with wb_addr=9 (sb[9]=1) and issue_en issue_rd=9 -> sb[9] stays 1.
- src0 req addr=0 data=0x1234 -> req_ready[0]=1, wb_en stays 0; issue_rd=0 -> issue_rd_busy=0.
- sb[3], sb[4] set, then flush=1 while a wb to x3 is registered -> all busy=0 next cycle, and the wb to x3 is still emitted with wb_en=1; rst_n low mid-stream -> wb_en=0 immediately.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Register file write-back controller: round-robin share of the single
// write port plus a per-register pending-write scoreboard for hazards.
`ifndef XLEN
`define XLEN 32
`endif

module regfile_wb_ctrl #(
    parameter int NUM_SRC   = 3,
    parameter int SRC_IDX_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req_valid,
    input  logic [5*NUM_SRC-1:0]      req_addr,
    input  logic [`XLEN*NUM_SRC-1:0]  req_data,
    output logic [NUM_SRC-1:0]        req_ready,
    output logic                      wb_en,
    output logic [4:0]                wb_addr,
    output logic [`XLEN-1:0]          wb_data,
    input  logic                      issue_en,
    input  logic [4:0]                issue_rd,
    input  logic [4:0]                rs1_q,
    input  logic [4:0]                rs2_q,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      issue_rd_busy,
    input  logic                      flush
);

    logic [SRC_IDX_W-1:0] rr_ptr;
    logic [SRC_IDX_W-1:0] rr_nxt;
    logic [SRC_IDX_W-1:0] gnt_idx;
    logic [NUM_SRC-1:0]   grant;
    logic                 hs;
    logic                 found;
    int                   cand;
    logic [4:0]           sel_addr;
    logic [`XLEN-1:0]     sel_data;
    logic [31:1]          sb;
    logic [31:1]          sb_nxt;
    logic [31:0]          sb_all;
    logic [4:0]           src_addr [NUM_SRC];
    logic [`XLEN-1:0]     src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_addr[i] = req_addr[5*i +: 5];
        assign src_data[i] = req_data[`XLEN*i +: `XLEN];
    end

    function automatic int wrap(input int v);
        return (v >= NUM_SRC) ? v - NUM_SRC : v;
    endfunction

    // Round-robin pick: first valid source at or above the pointer, wrapping.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = wrap(int'(rr_ptr) + k);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gnt_idx     = SRC_IDX_W'(cand);
            end
        end
        hs       = found;
        rr_nxt   = SRC_IDX_W'(wrap(int'(gnt_idx) + 1));
        sel_addr = src_addr[gnt_idx];
        sel_data = src_data[gnt_idx];
    end

    assign req_ready = grant;

    // Register the granted write; x0 writes are consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= hs && (sel_addr != 5'd0);
            if (hs && (sel_addr != 5'd0)) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
        end
    end

    // Advance the fairness pointer past the source just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= rr_nxt;
        end
    end

    // Scoreboard next state: clear on write-back, a new issue wins, flush wins all.
    always_comb begin
        sb_nxt = sb;
        if (wb_en && (wb_addr != 5'd0)) begin
            sb_nxt[wb_addr] = 1'b0;
        end
        if (issue_en && (issue_rd != 5'd0)) begin
            sb_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            sb_nxt = '0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= sb_nxt;
        end
    end

    assign sb_all        = {sb, 1'b0};
    assign rs1_busy      = sb_all[rs1_q];
    assign rs2_busy      = sb_all[rs2_q];
    assign issue_rd_busy = sb_all[issue_rd];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: arbitration order, write-back
// latency, scoreboard set/clear/flush and asynchronous reset.
`ifndef XLEN
`define XLEN 32
`endif

module tb_regfile_wb_ctrl;

    localparam int NS = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NS-1:0]         req_valid;
    logic [5*NS-1:0]       req_addr;
    logic [`XLEN*NS-1:0]   req_data;
    logic [NS-1:0]         req_ready;
    logic                  wb_en;
    logic [4:0]            wb_addr;
    logic [`XLEN-1:0]      wb_data;
    logic                  issue_en;
    logic [4:0]            issue_rd;
    logic [4:0]            rs1_q;
    logic [4:0]            rs2_q;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  issue_rd_busy;
    logic                  flush;

    int errors = 0;
    int checks = 0;

    regfile_wb_ctrl #(.NUM_SRC(NS), .SRC_IDX_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .issue_en      (issue_en),
        .issue_rd      (issue_rd),
        .rs1_q         (rs1_q),
        .rs2_q         (rs2_q),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .issue_rd_busy (issue_rd_busy),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] dat [3];
        dat[0] = 32'hA0A0_0001;
        dat[1] = 32'hB1B1_0002;
        dat[2] = 32'hC2C2_0003;

        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        issue_en  = 1'b0;
        issue_rd  = '0;
        rs1_q     = '0;
        rs2_q     = '0;
        flush     = 1'b0;
        #12;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rs1_q = 5'd5;
        rs2_q = 5'd31;
        #1;
        chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
        chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request from source 1.
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd5, 5'd0};
        req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
        #1;
        chk("single_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        #1;
        chk("single_wb_en", 32'(wb_en), 32'd1);
        chk("single_wb_addr", 32'(wb_addr), 32'd5);
        chk("single_wb_data", wb_data, 32'hDEADBEEF);
        chk("idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("single_wb_off", 32'(wb_en), 32'd0);
        chk("hold_wb_addr", 32'(wb_addr), 32'd5);
        chk("hold_wb_data", wb_data, 32'hDEADBEEF);

        // Continuous contention, fresh pointer.
        do_reset();
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {dat[2], dat[1], dat[0]};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_grant%0d", i), 32'(req_ready),
                32'(3'b001 << (i % 3)));
            tick();
            chk($sformatf("rr_wb_en%0d", i), 32'(wb_en), 32'd1);
            chk($sformatf("rr_wb_addr%0d", i), 32'(wb_addr),
                32'((i % 3) + 1));
            chk($sformatf("rr_wb_data%0d", i), wb_data, dat[i % 3]);
        end
        req_valid = '0;
        tick();

        // RAW: issue x7, then the LSU writes it back.
        issue_en = 1'b1;
        issue_rd = 5'd7;
        #1;
        chk("raw_pre_busy", 32'(issue_rd_busy), 32'd0);
        tick();
        issue_en = 1'b0;
        rs1_q    = 5'd7;
        #1;
        chk("raw_busy", 32'(rs1_busy), 32'd1);
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd7, 5'd0};
        req_data  = {32'h0, 32'h7777_0007, 32'h0};
        tick();
        req_valid = '0;
        #1;
        chk("raw_wb_addr", 32'(wb_addr), 32'd7);
        chk("raw_nobypass", 32'(rs1_busy), 32'd1);
        tick();
        chk("raw_cleared", 32'(rs1_busy), 32'd0);

        // Same-edge set and clear of x9: set wins.
        issue_en = 1'b1;
        issue_rd = 5'd9;
        tick();
        issue_en  = 1'b0;
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd9};
        req_data  = {32'h0, 32'h0, 32'h9999_0009};
        tick();
        req_valid = '0;
        issue_en  = 1'b1;
        issue_rd  = 5'd9;
        #1;
        chk("waw_wb_addr", 32'(wb_addr), 32'd9);
        chk("waw_rd_busy", 32'(issue_rd_busy), 32'd1);
        tick();
        issue_en = 1'b0;
        rs2_q    = 5'd9;
        #1;
        chk("setwins", 32'(rs2_busy), 32'd1);

        // Request to x0: granted but no write, scoreboard untouched.
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd0};
        req_data  = {32'h0, 32'h0, 32'h0000_1234};
        issue_rd  = 5'd0;
        issue_en  = 1'b1;
        #1;
        chk("x0_ready", 32'(req_ready), 32'b001);
        chk("x0_rd_busy", 32'(issue_rd_busy), 32'd0);
        tick();
        req_valid = '0;
        issue_en  = 1'b0;
        rs1_q     = 5'd0;
        #1;
        chk("x0_wb_en", 32'(wb_en), 32'd0);
        chk("x0_q_busy", 32'(rs1_busy), 32'd0);
        chk("x0_x9_kept", 32'(rs2_busy), 32'd1);

        // Flush with a write to x3 in flight.
        issue_en = 1'b1;
        issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_en = 1'b0;
        rs1_q    = 5'd3;
        rs2_q    = 5'd4;
        #1;
        chk("fl_busy3", 32'(rs1_busy), 32'd1);
        chk("fl_busy4", 32'(rs2_busy), 32'd1);
        req_valid = 3'b100;
        req_addr  = {5'd3, 5'd0, 5'd0};
        req_data  = {32'h3333_0003, 32'h0, 32'h0};
        flush     = 1'b1;
        tick();
        req_valid = '0;
        flush     = 1'b0;
        #1;
        chk("fl_busy3_clr", 32'(rs1_busy), 32'd0);
        chk("fl_busy4_clr", 32'(rs2_busy), 32'd0);
        rs2_q = 5'd9;
        #1;
        chk("fl_busy9_clr", 32'(rs2_busy), 32'd0);
        chk("fl_wb_en", 32'(wb_en), 32'd1);
        chk("fl_wb_addr", 32'(wb_addr), 32'd3);
        chk("fl_wb_data", wb_data, 32'h3333_0003);
        tick();

        // Asynchronous reset drops an in-flight write.
        issue_en = 1'b1;
        issue_rd = 5'd10;
        tick();
        issue_en  = 1'b0;
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd6};
        req_data  = {32'h0, 32'h0, 32'h6666_0006};
        tick();
        req_valid = '0;
        rs1_q     = 5'd10;
        #1;
        chk("mid_wb_en", 32'(wb_en), 32'd1);
        chk("mid_busy10", 32'(rs1_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wb_en", 32'(wb_en), 32'd0);
        chk("arst_wb_addr", 32'(wb_addr), 32'd0);
        chk("arst_busy10", 32'(rs1_busy), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
